lsu_data_port: RTL and testbench
================================

# lsu_data_port

Load/store unit that acts as the initiator on the data side of the byte-addressed, little-endian main memory (combinational 32-bit read, word write on posedge when write is high). It accepts one core request at a time through a valid/ready handshake and performs RV32 byte/halfword/word loads and stores. Sub-word stores use read-modify-write, because the memory write port always writes four bytes. Results return through a response handshake. The unit sits between the core's execute stage and the memory's `mem_data_*` ports; the instruction port is not touched.

## Interface
- `MEM_SIZE`, default `` `MEM_SIZE `` (from `defines.vh`): memory size in bytes; accesses past it are errors.
- `clk_i` in 1: clock; all state updates on posedge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when `req_valid_i && req_ready_o` at posedge.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_funct3_i` in 3: RV32 funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, right-aligned.
- `rsp_valid_o` out 1: response valid; held until accepted.
- `rsp_ready_i` in 1: core accepts response.
- `rsp_rdata_o` out 32: load result, extended; 0 for stores and errors.
- `rsp_err_o` out 1: misaligned, out-of-range or illegal funct3.
- `mem_data_addr_o` out 32: word-aligned address to memory.
- `mem_data_wdata_o` out 32: write data to memory.
- `mem_data_rdata_i` in 32: combinational read data from memory.
- `mem_write_o` out 1: memory write strobe.

## Operation
- The block has four states: IDLE, READ, WRITE, RESP. Reset forces IDLE and clears all registers.
- `req_ready_o` = (state == IDLE) && !rst_i.
- On accept, the block latches the request fields. `mem_data_addr_o` = {addr[31:2], 2'b00} from the latched register. Lane = addr[1:0].
- Error checks are evaluated on accept:
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] ≠ 0;
  - aligned address + 3 ≥ MEM_SIZE;
  - illegal funct3: loads 011/110/111; stores with funct3[2] = 1 or 011.
  - On error the next state is RESP with `rsp_err_o` = 1. No memory access is made and `mem_write_o` is never asserted.
- Transitions on accept with no error:
  - Loads and SB/SH go to READ.
  - SW goes to WRITE.
- READ: captures `mem_data_rdata_i` into the read register at posedge.
  - Loads then go to RESP.
  - Stores then go to WRITE.
- WRITE: `mem_write_o` = 1 for exactly one cycle, then RESP.
  - SW: write data = wdata.
  - SB: the read word with byte lane replaced by wdata[7:0].
  - SH: the read word with halfword lane addr[1] replaced by wdata[15:0].
- Load extraction from the read register by lane:
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- RESP: `rsp_valid_o` = 1. When `rsp_ready_i` = 1 at posedge, go to IDLE. Otherwise hold with `rsp_rdata_o`/`rsp_err_o` stable.
- `mem_write_o` = 1 only in WRITE. `mem_data_wdata_o` = 0 outside WRITE.
- Reset mid-operation: a synchronous `rst_i` in any state returns the block to IDLE on that edge. Any pending write is dropped if reset is high in the WRITE cycle: `mem_write_o` is gated by !rst_i.

## Timing
- Reset values: `req_ready_o` 0 while `rst_i` is high, then 1; `rsp_valid_o` 0, `rsp_rdata_o` 0, `rsp_err_o` 0, `mem_write_o` 0, `mem_data_addr_o` 0, `mem_data_wdata_o` 0.
- Latency is counted from accept edge N to the first cycle with `rsp_valid_o` high:
  - load: N+2;
  - SW: N+2, with the write at the edge ending cycle N+1;
  - SB/SH: N+3, with READ in N+1 and the write at the edge ending N+2;
  - error: N+1.
- A new request can be accepted no earlier than the cycle after response acceptance. There is no overlap.
- Request inputs are ignored outside the accept edge.

## Test plan
- Memory preloaded with 0x80FF7F01 at 0x10. Issue LB 0x10, LB 0x13, LBU 0x13, LH 0x12, LHU 0x12, LW 0x10. Required responses: 0x00000001, 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF, 0x80FF7F01, each at N+2.
- SB 0x11 with wdata 0xAB over 0x80FF7F01, then LW 0x10. Required: exactly one `mem_write_o` pulse at N+2 with wdata 0x80FFAB01; the load returns 0x80FFAB01.
- SW 0x20 with wdata 0xDEADBEEF. Required: `mem_write_o` at N+1 only, `rsp_valid_o` at N+2; LW 0x20 then returns 0xDEADBEEF.
- LH 0x11, SW 0x22, and LW at MEM_SIZE-4+4. Required: `rsp_err_o` = 1 at N+1, `rsp_rdata_o` 0, `mem_write_o` never high.
- Hold `rsp_ready_i` = 0 for 5 cycles during a load response. Required: `rsp_valid_o`/`rsp_rdata_o` stable and `req_ready_o` 0 throughout; IDLE resumes one cycle after `rsp_ready_i` = 1.
- Assert `rst_i` during the WRITE cycle of an SH. Required: no write occurs, memory is unchanged, and all outputs are at reset values the next cycle.

Source files
------------

// File: rtl/lsu_data_port_if.sv
// Core request/response and data-memory port bundle for the load/store unit.
// The slave modport is the LSU's view; master is the core plus memory side.
interface lsu_data_port_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] mem_data_addr_o;
  logic [31:0] mem_data_wdata_o;
  logic [31:0] mem_data_rdata_i;
  logic        mem_write_o;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    input  rsp_ready_i, mem_data_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_data_addr_o, mem_data_wdata_o, mem_write_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
    output rsp_ready_i, mem_data_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_data_addr_o, mem_data_wdata_o, mem_write_o
  );
endinterface

// File: rtl/lsu_data_port.sv
// RV32 load/store unit on the data port of a word-wide memory: one request at a
// time, sub-word stores done as read-modify-write.
`ifndef MEM_SIZE
`define MEM_SIZE 4096
`endif

module lsu_data_port #(
  parameter int unsigned MEM_SIZE = `MEM_SIZE
) (
  input logic             clk_i,
  input logic             rst_i,
  lsu_data_port_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic        bad_f3;
  logic        misaligned;
  logic        out_of_range;
  logic [32:0] last_byte;
  logic [31:0] wr_word;
  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign accept = bus.req_valid_i && bus.req_ready_o;

  // Request checks work on the live inputs; only the verdict is latched.
  always_comb begin
    if (bus.req_we_i)
      bad_f3 = bus.req_funct3_i[2] || (bus.req_funct3_i == 3'b011);
    else
      bad_f3 = (bus.req_funct3_i == 3'b011) || (bus.req_funct3_i == 3'b110) ||
               (bus.req_funct3_i == 3'b111);
    misaligned = ((bus.req_funct3_i[1:0] == 2'b01) && bus.req_addr_i[0]) ||
                 ((bus.req_funct3_i[1:0] == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
    last_byte    = {1'b0, bus.req_addr_i[31:2], 2'b00} + 33'd3;
    out_of_range = last_byte >= 33'(MEM_SIZE);
    req_err      = bad_f3 || misaligned || out_of_range;
  end

  always_comb begin
    ld_byte = rdata_q[{addr_q[1:0], 3'b000} +: 8];
    ld_half = rdata_q[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_word = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_word = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_word = rdata_q;
      3'b100:  ld_word = {24'h0, ld_byte};
      3'b101:  ld_word = {16'h0, ld_half};
      default: ld_word = '0;
    endcase
  end

  // Sub-word stores merge new data into the word captured in READ.
  always_comb begin
    wr_word = rdata_q;
    case (funct3_q[1:0])
      2'b00:   wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: wr_word = wdata_q;
    endcase
  end

  always_comb begin
    state_d              = state_q;
    bus.req_ready_o      = (state_q == IDLE) && !rst_i;
    bus.rsp_valid_o      = 1'b0;
    bus.rsp_rdata_o      = '0;
    bus.rsp_err_o        = 1'b0;
    bus.mem_write_o      = 1'b0;
    bus.mem_data_wdata_o = '0;
    bus.mem_data_addr_o  = {addr_q[31:2], 2'b00};
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)
            state_d = RESP;
          else if (bus.req_we_i && (bus.req_funct3_i[1:0] == 2'b10))
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ:  state_d = we_q ? WRITE : RESP;
      WRITE: begin
        bus.mem_write_o      = !rst_i;
        bus.mem_data_wdata_o = rst_i ? '0 : wr_word;
        state_d              = RESP;
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_err_o   = err_q;
        bus.rsp_rdata_o = (err_q || we_q) ? '0 : ld_word;
        if (bus.rsp_ready_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= bus.req_addr_i;
        funct3_q <= bus.req_funct3_i;
        we_q     <= bus.req_we_i;
        wdata_q  <= bus.req_wdata_i;
        err_q    <= req_err;
      end
      if (state_q == READ)
        rdata_q <= bus.mem_data_rdata_i;
    end
  end

endmodule

// File: tb/tb_lsu_data_port.sv
// Scoreboard bench for lsu_data_port against a small word memory model.
module tb_lsu_data_port;

  localparam int unsigned MEM_SIZE  = 256;
  localparam int unsigned MEM_WORDS = MEM_SIZE / 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b1;
  logic [31:0] mem [MEM_WORDS];
  rsp_t sb_q[$];
  int n_tests = 0;
  int n_fail = 0;

  lsu_data_port_if bus ();

  lsu_data_port #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.mem_data_rdata_i = '0;
    if (bus.mem_data_addr_o < MEM_SIZE)
      bus.mem_data_rdata_i = mem[bus.mem_data_addr_o[7:2]];
  end

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
      mem[4]  <= 32'h80FF7F01;
      mem[12] <= 32'h11223344;
      mem[63] <= 32'hCAFEF00D;
    end else if (bus.mem_write_o && (bus.mem_data_addr_o < MEM_SIZE)) begin
      mem[bus.mem_data_addr_o[7:2]] <= bus.mem_data_wdata_o;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".req_ready"}, 32'(bus.req_ready_o), 32'(!rst));
    check_eq({tag, ".rsp_valid"}, 32'(bus.rsp_valid_o), 0);
    check_eq({tag, ".rsp_rdata"}, bus.rsp_rdata_o, 0);
    check_eq({tag, ".rsp_err"}, 32'(bus.rsp_err_o), 0);
    check_eq({tag, ".mem_write"}, 32'(bus.mem_write_o), 0);
    check_eq({tag, ".mem_addr"}, bus.mem_data_addr_o, 0);
    check_eq({tag, ".mem_wdata"}, bus.mem_data_wdata_o, 0);
  endtask

  // Issue one request from a negedge in IDLE, track latency and writes, then
  // hold the response for 'hold' cycles before accepting it.
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input int wr_k, input logic [31:0] wr_data,
                         input int hold);
    rsp_t exp;
    rsp_t got;
    int   k;
    int   wr_cnt;
    exp.rdata = exp_rd;
    exp.err   = exp_err;
    sb_q.push_back(exp);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wdata;
    check_eq({tag, ".req_ready"}, 32'(bus.req_ready_o), 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'($urandom());
    bus.req_funct3_i = 3'($urandom());
    bus.req_addr_i   = $urandom();
    bus.req_wdata_i  = $urandom();
    k = 1;
    wr_cnt = 0;
    while (!bus.rsp_valid_o && k < 8) begin
      if (bus.mem_write_o) begin
        wr_cnt++;
        check_eq({tag, ".wr_cycle"}, k, wr_k);
        check_eq({tag, ".wr_data"}, bus.mem_data_wdata_o, wr_data);
        check_eq({tag, ".wr_addr"}, bus.mem_data_addr_o, {addr[31:2], 2'b00});
      end
      @(negedge clk);
      k++;
    end
    check_eq({tag, ".latency"}, k, lat);
    check_eq({tag, ".wr_count"}, wr_cnt, (wr_k != 0) ? 1 : 0);
    for (int h = 0; h < hold; h++) begin
      check_eq({tag, ".hold_valid"}, 32'(bus.rsp_valid_o), 1);
      check_eq({tag, ".hold_rdata"}, bus.rsp_rdata_o, exp_rd);
      check_eq({tag, ".hold_ready"}, 32'(bus.req_ready_o), 0);
      @(negedge clk);
    end
    got.rdata = bus.rsp_rdata_o;
    got.err   = bus.rsp_err_o;
    bus.rsp_ready_i = 1'b1;
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check_eq({tag, ".rdata"}, got.rdata, exp.rdata);
      check_eq({tag, ".err"}, 32'(got.err), 32'(exp.err));
    end
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check_eq({tag, ".idle_valid"}, 32'(bus.rsp_valid_o), 0);
    check_eq({tag, ".idle_ready"}, 32'(bus.req_ready_o), 1);
  endtask

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = '0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.rsp_ready_i  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    init = 1'b0;
    rst  = 1'b0;
    @(negedge clk);
    check_eq("post_reset.req_ready", 32'(bus.req_ready_o), 1);

    run_req("lb_10",  1'b0, 3'b000, 32'h10, 0, 32'h00000001, 1'b0, 2, 0, 0, 0);
    run_req("lb_13",  1'b0, 3'b000, 32'h13, 0, 32'hFFFFFF80, 1'b0, 2, 0, 0, 0);
    run_req("lbu_13", 1'b0, 3'b100, 32'h13, 0, 32'h00000080, 1'b0, 2, 0, 0, 0);
    run_req("lh_12",  1'b0, 3'b001, 32'h12, 0, 32'hFFFF80FF, 1'b0, 2, 0, 0, 0);
    run_req("lhu_12", 1'b0, 3'b101, 32'h12, 0, 32'h000080FF, 1'b0, 2, 0, 0, 0);
    run_req("lw_10",  1'b0, 3'b010, 32'h10, 0, 32'h80FF7F01, 1'b0, 2, 0, 0, 0);

    run_req("sb_11",  1'b1, 3'b000, 32'h11, 32'h000000AB, 0, 1'b0, 3, 2, 32'h80FFAB01, 0);
    run_req("lw_10b", 1'b0, 3'b010, 32'h10, 0, 32'h80FFAB01, 1'b0, 2, 0, 0, 0);
    run_req("sh_12",  1'b1, 3'b001, 32'h12, 32'hFFFF1234, 0, 1'b0, 3, 2, 32'h1234AB01, 0);
    run_req("lw_hold", 1'b0, 3'b010, 32'h10, 0, 32'h1234AB01, 1'b0, 2, 0, 0, 5);

    run_req("sw_20",  1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 1'b0, 2, 1, 32'hDEADBEEF, 0);
    run_req("lw_20",  1'b0, 3'b010, 32'h20, 0, 32'hDEADBEEF, 1'b0, 2, 0, 0, 0);
    run_req("lw_last", 1'b0, 3'b010, MEM_SIZE - 4, 0, 32'hCAFEF00D, 1'b0, 2, 0, 0, 0);

    run_req("err_lh_11", 1'b0, 3'b001, 32'h11, 0, 0, 1'b1, 1, 0, 0, 0);
    run_req("err_sw_22", 1'b1, 3'b010, 32'h22, 32'h12345678, 0, 1'b1, 1, 0, 0, 0);
    run_req("err_range", 1'b0, 3'b010, MEM_SIZE, 0, 0, 1'b1, 1, 0, 0, 0);
    run_req("err_ld_f3", 1'b0, 3'b011, 32'h10, 0, 0, 1'b1, 1, 0, 0, 0);
    run_req("err_st_f3", 1'b1, 3'b100, 32'h10, 32'h55, 0, 1'b1, 1, 0, 0, 2);
    run_req("lw_20_intact", 1'b0, 3'b010, 32'h20, 0, 32'hDEADBEEF, 1'b0, 2, 0, 0, 0);

    // Reset lands in the WRITE cycle of an SH: the write must be suppressed.
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b1;
    bus.req_funct3_i = 3'b001;
    bus.req_addr_i   = 32'h30;
    bus.req_wdata_i  = 32'h00005566;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    check_eq("rst_sh.read_nowrite", 32'(bus.mem_write_o), 0);
    @(negedge clk);
    check_eq("rst_sh.write_cycle", 32'(bus.mem_write_o), 1);
    rst = 1'b1;
    #1;
    check_eq("rst_sh.write_gated", 32'(bus.mem_write_o), 0);
    @(negedge clk);
    check_reset_outputs("rst_sh");
    check_eq("rst_sh.mem_model", mem[12], 32'h11223344);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_sh.ready_back", 32'(bus.req_ready_o), 1);
    run_req("lw_30", 1'b0, 3'b010, 32'h30, 0, 32'h11223344, 1'b0, 2, 0, 0, 0);

    check_eq("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
